// File: rtl/tg_rd_data_checker.sv
// Read-data checker for the traffic generator: buffers expected words in a FIFO,
// compares returning reads against the head and keeps error statistics.
module tg_rd_data_checker #(
  parameter int    TCQ            = 100,
  parameter int    APP_DATA_WIDTH = 576,
  parameter int    NUM_DQ_PINS    = 72,
  parameter int    nCK_PER_CLK    = 4,
  parameter string MEM_TYPE       = "DDR4",
  parameter string MEM_ARCH       = "ULTRASCALE",
  parameter int    EXP_FIFO_LOG2  = 4,
  parameter int    CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      chk_en,
  input  logic                      chk_clear,
  input  logic                      exp_valid,
  input  logic [APP_DATA_WIDTH-1:0] exp_data,
  output logic                      exp_ready,
  input  logic                      rd_valid,
  input  logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      err_valid,
  output logic [APP_DATA_WIDTH-1:0] err_bits,
  output logic [NUM_DQ_PINS-1:0]    err_dq_sticky,
  output logic [CNT_WIDTH-1:0]      rd_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt,
  output logic                      first_err_valid,
  output logic [CNT_WIDTH-1:0]      first_err_idx,
  output logic [APP_DATA_WIDTH-1:0] first_err_rd,
  output logic [APP_DATA_WIDTH-1:0] first_err_exp,
  output logic                      exp_overflow,
  output logic                      exp_underflow,
  output logic [EXP_FIFO_LOG2:0]    exp_level
);

  localparam int DEPTH = 2 ** EXP_FIFO_LOG2;
  localparam int BEATS = 2 * nCK_PER_CLK;
  localparam logic [EXP_FIFO_LOG2:0] FULL_LEVEL = (EXP_FIFO_LOG2 + 1)'(DEPTH);
  localparam bit LINEAR_LAYOUT = (MEM_ARCH == "7SERIES") || (MEM_TYPE == "RLD3") ||
                                 (MEM_TYPE == "QDRIIP") || (MEM_TYPE == "QDRIV");

  logic [APP_DATA_WIDTH-1:0] mem [DEPTH];
  logic [EXP_FIFO_LOG2-1:0]  wr_ptr, rd_ptr;
  logic                      push, pop, rd_req, fifo_empty;
  logic                      v1;
  logic [APP_DATA_WIDTH-1:0] rd_r, exp_r, diff;
  logic                      mis;
  logic [NUM_DQ_PINS-1:0]    dq_fold;
  logic                      unused_tcq;

  assign unused_tcq = (TCQ != 0);

  assign exp_ready  = (exp_level != FULL_LEVEL);
  assign fifo_empty = (exp_level == '0);
  assign push       = exp_valid & exp_ready;
  assign rd_req     = rd_valid & chk_en;
  // No bypass: a read only pops what was already stored before this cycle.
  assign pop        = rd_req & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      exp_level <= exp_level + 1'b1;
      else if (pop && !push) exp_level <= exp_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= pop;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      exp_r <= mem[rd_ptr];
      rd_r  <= rd_data;
    end
  end

  assign diff = rd_r ^ exp_r;
  assign mis  = |diff;

  // Fold every beat of each DQ pin onto that pin according to the lane layout.
  for (genvar p = 0; p < NUM_DQ_PINS; p++) begin : g_pin
    logic [BEATS-1:0] beat_bits;
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      localparam int BIT = LINEAR_LAYOUT ? (NUM_DQ_PINS * b + p)
                                         : (64 * (p / 8) + 8 * b + (p % 8));
      assign beat_bits[b] = diff[BIT];
    end
    assign dq_fold[p] = |beat_bits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid       <= 1'b0;
      err_bits        <= '0;
      err_dq_sticky   <= '0;
      rd_cnt          <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_rd    <= '0;
      first_err_exp   <= '0;
      exp_overflow    <= 1'b0;
      exp_underflow   <= 1'b0;
    end else begin
      err_valid <= v1 & mis;
      // Clear wins over a same-cycle compare; that word's statistics are lost.
      if (chk_clear) begin
        err_bits        <= '0;
        err_dq_sticky   <= '0;
        rd_cnt          <= '0;
        err_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        first_err_rd    <= '0;
        first_err_exp   <= '0;
        exp_overflow    <= 1'b0;
        exp_underflow   <= 1'b0;
      end else begin
        if (exp_valid && !exp_ready) exp_overflow  <= 1'b1;
        if (rd_req && fifo_empty)    exp_underflow <= 1'b1;
        if (v1) begin
          rd_cnt <= rd_cnt + 1'b1;
          if (mis) begin
            err_bits      <= diff;
            err_dq_sticky <= err_dq_sticky | dq_fold;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= rd_cnt;
              first_err_rd    <= rd_r;
              first_err_exp   <= exp_r;
            end
          end
        end
      end
    end
  end

endmodule
